// File: rtl/dcache_pkg.sv
// -----------------------------------------------------------------------------
// dcache_pkg : shared state encoding and ASCII helpers for the frame buffer
// Revision   : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_9     = 8'h39;
  localparam logic [7:0] ASC_DOT   = 8'h2E;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_SP    = 8'h20;

  // Characters a numeric display frame may legally contain.
  function automatic logic is_valid_ascii(input logic [7:0] b);
    return ((b >= ASC_0) && (b <= ASC_9)) || (b == ASC_DOT) ||
           (b == ASC_MINUS) || (b == ASC_SP);
  endfunction

endpackage

`default_nettype wire

// File: rtl/frame_gap_timer.sv
// -----------------------------------------------------------------------------
// frame_gap_timer : counts idle cycles, pulses expire on the TIMEOUT-th one
// Revision        : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module frame_gap_timer #(
  parameter int TIMEOUT = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expire = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || expire) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dcache_frame_buf.sv
// -----------------------------------------------------------------------------
// dcache_frame_buf : assembles FRA UART bytes MSB-first into CH channel regs
// Revision         : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module dcache_frame_buf
  import dcache_pkg::*;
#(
  parameter int FRA       = 5,
  parameter int CH        = 4,
  parameter int AW        = $clog2(CH),
  parameter int TIMEOUT   = 50000,
  parameter int CHK_ASCII = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            din,
  input  logic                  dout_vld,
  input  logic [AW-1:0]         add,
  output logic [CH*FRA*8-1:0]   ch_data,
  output logic [CH-1:0]         upd,
  output logic                  busy,
  output logic                  err,
  output logic [7:0]            err_cnt
);

  localparam int FW   = FRA * 8;
  localparam int CNTW = $clog2(FRA + 1);

  state_t              state_q, state_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [FW-1:0]       shadow_q, shadow_d;
  logic                bad_q, bad_d;
  logic [AW-1:0]       add_q, add_d;
  logic [CH*FW-1:0]    ch_q, ch_d;
  logic [CH-1:0]       upd_q, upd_d;
  logic                err_q, err_d;
  logic [7:0]          err_cnt_q, err_cnt_d;

  logic                timer_en;
  logic                timer_clr;
  logic                timer_exp;
  logic                byte_bad;
  logic                start_frame;
  logic                store_byte;
  logic [CNTW-1:0]     store_idx;

  assign timer_en  = (state_q == RECV) && !dout_vld;
  assign timer_clr = (state_q != RECV) || dout_vld;

  frame_gap_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_gap_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (timer_clr),
    .en     (timer_en),
    .expire (timer_exp)
  );

  assign byte_bad    = (CHK_ASCII != 0) && !is_valid_ascii(din);
  // A strobe in the COMMIT cycle opens the next frame, so nothing is lost.
  assign start_frame = dout_vld && ((state_q == IDLE) || (state_q == COMMIT));
  assign store_byte  = start_frame || (dout_vld && (state_q == RECV));
  assign store_idx   = start_frame ? '0 : cnt_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    bad_d     = bad_q;
    add_d     = add_q;
    ch_d      = ch_q;
    upd_d     = '0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      RECV: begin
        if (dout_vld) begin
          cnt_d = cnt_q + CNTW'(1);
          bad_d = bad_q | byte_bad;
          if (cnt_q == CNTW'(FRA - 1)) begin
            state_d = COMMIT;
          end
        end else if (timer_exp) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          bad_d   = 1'b0;
          state_d = IDLE;
        end
      end
      COMMIT: begin
        if (!bad_q) begin
          for (int i = 0; i < CH; i++) begin
            if (add_q == AW'(i)) begin
              ch_d[i*FW +: FW] = shadow_q;
              upd_d[i]         = 1'b1;
            end
          end
        end else begin
          err_d = 1'b1;
        end
        cnt_d   = '0;
        bad_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        bad_d   = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (start_frame) begin
      add_d   = add;
      cnt_d   = CNTW'(1);
      bad_d   = byte_bad;
      state_d = (FRA == 1) ? COMMIT : RECV;
    end

    if (store_byte) begin
      for (int k = 0; k < FRA; k++) begin
        if (store_idx == CNTW'(k)) begin
          shadow_d[(FRA-k)*8-1 -: 8] = din;
        end
      end
    end

    if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shadow_q  <= '0;
      bad_q     <= 1'b0;
      add_q     <= '0;
      ch_q      <= '0;
      upd_q     <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      bad_q     <= bad_d;
      add_q     <= add_d;
      ch_q      <= ch_d;
      upd_q     <= upd_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign ch_data = ch_q;
  assign upd     = upd_q;
  assign busy    = (state_q != IDLE);
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_dcache_frame_buf.sv
// -----------------------------------------------------------------------------
// tb_dcache_frame_buf : directed + random frames against a frame-level model
// Revision            : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_dcache_frame_buf;

  localparam int FRA = 5;
  localparam int CH  = 4;
  localparam int AW  = 2;
  localparam int TO  = 20;
  localparam int FW  = FRA * 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    din;
  logic          dout_vld;
  logic [AW-1:0] add;

  logic [CH*FW-1:0] ch_c, ch_r;
  logic [CH-1:0]    upd_c, upd_r;
  logic             busy_c, busy_r, err_c, err_r;
  logic [7:0]       ecnt_c, ecnt_r;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dcache_frame_buf #(.FRA(FRA), .CH(CH), .AW(AW), .TIMEOUT(TO), .CHK_ASCII(1)) u_dut_chk (
    .clk(clk), .rst_n(rst_n), .din(din), .dout_vld(dout_vld), .add(add),
    .ch_data(ch_c), .upd(upd_c), .busy(busy_c), .err(err_c), .err_cnt(ecnt_c)
  );

  dcache_frame_buf #(.FRA(FRA), .CH(CH), .AW(AW), .TIMEOUT(TO), .CHK_ASCII(0)) u_dut_raw (
    .clk(clk), .rst_n(rst_n), .din(din), .dout_vld(dout_vld), .add(add),
    .ch_data(ch_r), .upd(upd_r), .busy(busy_r), .err(err_r), .err_cnt(ecnt_r)
  );

  // Frame-level model; index 0 checks ASCII, index 1 does not.
  logic [7:0]    fb    [2][FRA];
  int            nb    [2];
  int            faddr [2];
  bit            fbad  [2];
  int            idle  [2];
  bit            pend  [2];
  logic [FW-1:0] chm   [2][CH];
  logic [CH-1:0] um    [2];
  bit            em    [2];
  int            ecnt  [2];

  function automatic bit legal_char(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) || b == 8'h2E || b == 8'h2D || b == 8'h20;
  endfunction

  function automatic logic [FW-1:0] pack(input int m);
    logic [FW-1:0] r;
    r = '0;
    for (int k = 0; k < FRA; k++) r[(FRA-k)*8-1 -: 8] = fb[m][k];
    return r;
  endfunction

  task automatic model_clear(input int m);
    nb[m] = 0; faddr[m] = 0; fbad[m] = 0; idle[m] = 0; pend[m] = 0;
    um[m] = '0; em[m] = 0; ecnt[m] = 0;
    for (int i = 0; i < CH; i++) chm[m][i] = '0;
  endtask

  task automatic model_step(input int m);
    um[m] = '0;
    em[m] = 0;
    if (pend[m]) begin
      if (fbad[m]) begin
        em[m] = 1;
        if (ecnt[m] < 255) ecnt[m]++;
      end else begin
        chm[m][faddr[m]] = pack(m);
        um[m][faddr[m]]  = 1'b1;
      end
      pend[m] = 0;
      nb[m]   = 0;
    end
    if (dout_vld) begin
      if (nb[m] == 0) begin
        faddr[m] = int'(add);
        fbad[m]  = 0;
      end
      fb[m][nb[m]] = din;
      if (m == 0 && !legal_char(din)) fbad[m] = 1;
      nb[m]++;
      idle[m] = 0;
      if (nb[m] == FRA) pend[m] = 1;
    end else if (nb[m] > 0) begin
      idle[m]++;
      if (idle[m] == TO) begin
        em[m] = 1;
        if (ecnt[m] < 255) ecnt[m]++;
        nb[m]   = 0;
        idle[m] = 0;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_clear(0);
      model_clear(1);
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      logic [CH*FW-1:0] flat;
      flat = '0;
      for (int i = 0; i < CH; i++) flat[i*FW +: FW] = chm[m][i];
      check($sformatf("ch_data[%0d]", m), (m == 0) ? ch_c : ch_r, flat);
      check($sformatf("upd[%0d]", m), (m == 0) ? upd_c : upd_r, um[m]);
      check($sformatf("err[%0d]", m), (m == 0) ? err_c : err_r, em[m]);
      check($sformatf("err_cnt[%0d]", m), (m == 0) ? ecnt_c : ecnt_r, 8'(ecnt[m]));
      check($sformatf("busy[%0d]", m), (m == 0) ? busy_c : busy_r, nb[m] > 0);
    end
  end

  function automatic logic [FW-1:0] chan(input logic [CH*FW-1:0] f, input int i);
    return f[i*FW +: FW];
  endfunction

  task automatic send(input logic [7:0] b, input logic [AW-1:0] a);
    din = b; add = a; dout_vld = 1'b1;
    @(posedge clk); #1;
    dout_vld = 1'b0;
  endtask

  task automatic send_frame(input logic [FW-1:0] s, input logic [AW-1:0] a);
    for (int k = 0; k < FRA; k++) send(s[(FRA-k)*8-1 -: 8], a);
  endtask

  task automatic wait_cyc(input int n);
    dout_vld = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  logic [7:0] vt [13];

  initial begin
    for (int i = 0; i < 10; i++) vt[i] = 8'h30 + 8'(i);
    vt[10] = 8'h2E; vt[11] = 8'h2D; vt[12] = 8'h20;
    rst_n = 1'b0; dout_vld = 1'b0; din = '0; add = '0;
    wait_cyc(3);
    check("reset ch_data", ch_c, '0);
    check("reset err_cnt", ecnt_c, 8'd0);
    rst_n = 1'b1;
    wait_cyc(2);

    // Reset mid-frame: partial frame vanishes without an error.
    send("7", 1); send("8", 1); send("9", 1);
    rst_n = 1'b0;
    #1;
    check("midreset busy", busy_c, 1'b0);
    check("midreset err_cnt", ecnt_c, 8'd0);
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(1);

    send_frame("1.234", 2);
    wait_cyc(1);
    check("frame ch_data all", ch_c, {40'h0, 40'h312E323334, 80'h0});
    check("frame upd", upd_c, 4'b0100);
    check("frame err_cnt", ecnt_c, 8'd0);

    // Partial frame then a gap longer than the timeout.
    send("9", 3); send("9", 3); send("9", 3);
    wait_cyc(TO + 3);
    check("timeout err_cnt", ecnt_c, 8'd1);
    send_frame("5.678", 0);
    wait_cyc(1);
    check("after timeout ch0", chan(ch_c, 0), 40'h352E363738);
    check("after timeout ch3", chan(ch_c, 3), 40'h0);

    send_frame("12A45", 1);
    wait_cyc(1);
    check("ascii reject ch1", chan(ch_c, 1), 40'h0);
    check("ascii reject err_cnt", ecnt_c, 8'd2);
    check("ascii off ch1", chan(ch_r, 1), 40'h3132413435);
    check("ascii off err_cnt", ecnt_r, 8'd1);

    // Address sampled only with byte 0.
    send("9", 3); send(".", 3); send("8", 0); send("7", 0); send("6", 0);
    wait_cyc(1);
    check("addr latch upd", upd_c, 4'b1000);
    check("addr latch ch3", chan(ch_c, 3), 40'h392E383736);
    check("addr latch ch0", chan(ch_c, 0), 40'h352E363738);

    // Back-to-back frames; second byte 0 lands in the COMMIT cycle.
    send_frame("11111", 0);
    send_frame("22222", 1);
    wait_cyc(1);
    check("b2b ch0", chan(ch_c, 0), 40'h3131313131);
    check("b2b ch1", chan(ch_c, 1), 40'h3232323232);
    check("b2b err_cnt", ecnt_c, 8'd2);

    for (int it = 0; it < 1500; it++) begin
      logic [7:0] b;
      int gap;
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        wait_cyc($urandom_range(1, 3));
        rst_n = 1'b1;
      end
      b = ($urandom_range(0, 7) == 0) ? 8'($urandom) : vt[$urandom_range(0, 12)];
      send(b, AW'($urandom));
      if ($urandom_range(0, 29) == 0) gap = TO - 2 + int'($urandom_range(0, 3));
      else gap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : 0;
      wait_cyc(gap);
    end
    wait_cyc(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dcache_frame_buf.md
Name: dcache_frame_buf

Overview:
- Parametrised successor to the UART data cache. Assembles FRA consecutive received bytes, MSB first, into one frame and commits it to one of CH channel registers selected by the address lines from the Arduino.
- Sits between uart_rx (din/dout_vld) and the display/control logic.
- Fully synchronous to clk: dout_vld is sampled as a strobe, not used as a clock.
- Adds address latching, inter-byte timeout, optional ASCII validation, per-channel update pulses and error counting.

Parameters:
- FRA, 5, bytes per frame (>=1).
- CH, 4, number of channel registers (>=2).
- AW, $clog2(CH), address width.
- TIMEOUT, 50000, clk cycles of inter-byte gap before a partial frame is dropped.
- CHK_ASCII, 1, 1 = reject frames containing bytes other than '0'-'9', '.', '-', ' '.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- din  in  8  received byte from uart_rx
- dout_vld  in  1  one-cycle strobe; din valid in this cycle
- add  in  AW  target channel, sampled with first byte of frame
- ch_data  out  CH*FRA*8  flat channel registers; channel i at [i*FRA*8 +: FRA*8]
- upd  out  CH  one-cycle pulse, bit i = channel i just committed
- busy  out  1  frame in progress (state != IDLE)
- err  out  1  one-cycle pulse on dropped or rejected frame
- err_cnt  out  8  saturating count of err pulses

Behaviour:
- Reset (async, rst_n=0): state IDLE, byte counter 0, shadow 0, all ch_data 0, upd 0, err 0, err_cnt 0, gap timer 0, bad flag 0, latched address 0. Reset mid-frame discards the partial frame with no err.
- Byte placement: byte k (0-based) of a frame goes to shadow[(FRA-k)*8-1 -: 8]. The first byte received is the most significant.
- State IDLE:
  - On dout_vld: latch add into add_q, store byte 0, counter=1, bad=invalid(din).
  - Go to RECV, or to COMMIT if FRA==1.
- State RECV:
  - On dout_vld: store byte at counter, counter++, bad|=invalid(din), gap timer cleared.
  - When byte FRA-1 is stored, go to COMMIT.
- Gap timer:
  - Counts every RECV cycle without dout_vld.
  - On reaching TIMEOUT-1: drop frame, err=1 for one cycle, go IDLE, counter=0.
  - A dout_vld in the same cycle as the timeout wins: the byte is stored and no drop occurs.
- State COMMIT (exactly one cycle):
  - bad==0: ch_data[add_q] <= shadow, upd[add_q]=1 for one cycle.
  - bad==1: no register write, err=1 for one cycle.
  - Counter=0, bad=0, then IDLE.
- dout_vld during COMMIT: treated as byte 0 of the next frame. add is latched, counter=1, and the next state is RECV. No byte is lost.
- Latency: last byte strobed at edge N, COMMIT state during cycle N..N+1, ch_data/upd registered at edge N+1.
- Address: add changes after byte 0 are ignored for the current frame.
- CHK_ASCII=0: bad is always 0.
- Other outputs:
  - err_cnt saturates at 255.
  - upd and err are never both high.
  - Uncommitted channels hold their value indefinitely.
- Back-to-back strobes on consecutive cycles must be accepted.

Decomposition:
- Package dcache_pkg:
  - state enum {IDLE, RECV, COMMIT}
  - ASCII constants ASC_0, ASC_9, ASC_DOT, ASC_MINUS, ASC_SP
  - function is_valid_ascii(byte)
- Sub-module frame_gap_timer: counter with clear/enable inputs, TIMEOUT parameter, one-cycle expire output.
- Channel register bank stays in the top module.

Test Plan:
- Send '1','.','2','3','4' (0x31,0x2E,0x32,0x33,0x34) with add=2 -> ch 2 = 0x312E323334 one cycle after the last strobe, upd=4'b0100 for one cycle, all other channels 0.
- Send 3 bytes then idle TIMEOUT cycles, then "5.678" with add=0 -> err pulse once, err_cnt=1, then ch 0 = 0x352E363738 with no corruption from the partial frame.
- Send "12A45" with CHK_ASCII=1, add=1 -> no ch 1 write, err pulse, err_cnt increments. Same stimulus with CHK_ASCII=0 -> ch 1 = 0x3132413435.
- Toggle add from 3 to 0 after byte 1 of "9.876" -> commit goes to ch 3 only, upd=4'b1000.
- Two frames with strobes on consecutive cycles, the second frame's byte 0 landing in the COMMIT cycle, to add=0 then add=1 -> both channels correct, two upd pulses, no err.
- Assert rst_n low after byte 2, release, send a full frame -> all outputs 0 during reset, err_cnt unchanged at 0, new frame committed correctly.
